conv1_stream_feeder: RTL and testbench

Sequencer that drives the input side of the six-filter first convolution layer. It walks every valid output position of a C×H×W input feature map and reads the matching pixels from an image memory. It reads the six filters' weights for each kernel tap from a weight memory. It emits one pixel/weight term per cycle on the layer's data1..6 / weight1..6 inputs, marking window boundaries so the downstream per-filter accumulators know where each dot product starts and ends.

---
 rtl/conv1_stream_feeder.sv | 245 ++++++++++++++++++++++++
 tb/tb_conv1_stream_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv1_stream_feeder.sv
// Input-side sequencer for the six-filter first convolution layer.
// Walks every valid output position, issues image/weight reads one tap per
// cycle, and presents the returned pixel plus six filter weights as a gapless
// term stream tagged with window first/last markers.

// One output lane: gates the shared pixel and its filter's weight so that
// idle cycles present zeros to the downstream accumulator.
module conv1_lane #(
  parameter int BITWIDTH = 8
) (
  input  logic                vld,
  input  logic [BITWIDTH-1:0] pix,
  input  logic [BITWIDTH-1:0] wgt,
  output logic [BITWIDTH-1:0] data,
  output logic [BITWIDTH-1:0] weight
);
  // zero the term whenever no live read is returning
  always_comb begin
    data   = vld ? pix : '0;
    weight = vld ? wgt : '0;
  end
endmodule

module conv1_stream_feeder #(
  parameter int BITWIDTH       = 8,
  parameter int FILTER_WIDTH   = 5,
  parameter int FILTER_HEIGHT  = 5,
  parameter int FILTER_CHANNEL = 3,
  parameter int IMG_WIDTH      = 32,
  parameter int IMG_HEIGHT     = 32,
  parameter int IMG_ADDR_W     = 12,
  parameter int WGT_ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IMG_ADDR_W-1:0] img_addr,
  input  logic [BITWIDTH-1:0]   img_data,
  output logic [WGT_ADDR_W-1:0] wgt_addr,
  input  logic [6*BITWIDTH-1:0] wgt_data,
  output logic                  term_valid,
  output logic                  win_first,
  output logic                  win_last,
  output logic [7:0]            out_row,
  output logic [7:0]            out_col,
  output logic [BITWIDTH-1:0]   data1,
  output logic [BITWIDTH-1:0]   data2,
  output logic [BITWIDTH-1:0]   data3,
  output logic [BITWIDTH-1:0]   data4,
  output logic [BITWIDTH-1:0]   data5,
  output logic [BITWIDTH-1:0]   data6,
  output logic [BITWIDTH-1:0]   weight1,
  output logic [BITWIDTH-1:0]   weight2,
  output logic [BITWIDTH-1:0]   weight3,
  output logic [BITWIDTH-1:0]   weight4,
  output logic [BITWIDTH-1:0]   weight5,
  output logic [BITWIDTH-1:0]   weight6
);
  localparam int NUM_LANES = 6;
  localparam int STAGES    = 1;
  localparam int OH        = IMG_HEIGHT - FILTER_HEIGHT + 1;
  localparam int OW        = IMG_WIDTH - FILTER_WIDTH + 1;
  localparam int PLANE     = IMG_HEIGHT * IMG_WIDTH;

  localparam logic [IMG_ADDR_W-1:0] W_STEP     = IMG_ADDR_W'(IMG_WIDTH);
  localparam logic [IMG_ADDR_W-1:0] PLANE_STEP = IMG_ADDR_W'(PLANE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // window tag travelling alongside the read in flight
  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] row;
    logic [7:0] col;
  } tag_t;

  state_t state, state_nx;

  // loop counters, innermost first
  logic [7:0] kx, ky, ch, ocol, orow;
  // running bases: row start of current output row, window origin,
  // channel origin within window, kernel-row origin within channel
  logic [IMG_ADDR_W-1:0] line_base, win_base, ch_base, row_base;
  logic [IMG_ADDR_W-1:0] img_q;
  logic [WGT_ADDR_W-1:0] wgt_q;

  logic issue;
  logic kx_last, ky_last, ch_last, col_last, row_last, tap_last, final_tap;

  assign issue     = (state == S_RUN);
  assign kx_last   = (kx   == 8'(FILTER_WIDTH - 1));
  assign ky_last   = (ky   == 8'(FILTER_HEIGHT - 1));
  assign ch_last   = (ch   == 8'(FILTER_CHANNEL - 1));
  assign col_last  = (ocol == 8'(OW - 1));
  assign row_last  = (orow == 8'(OH - 1));
  assign tap_last  = kx_last & ky_last & ch_last;
  assign final_tap = tap_last & col_last & row_last;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state: one pass per accepted start, start ignored otherwise
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (final_tap) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // address walk: adders only, every base steps by a constant; counters and
  // bases all fall back to zero after the final tap so idle addresses are 0
  always_ff @(posedge clk) begin
    if (reset) begin
      kx <= '0; ky <= '0; ch <= '0; ocol <= '0; orow <= '0;
      line_base <= '0; win_base <= '0; ch_base <= '0; row_base <= '0;
      img_q <= '0; wgt_q <= '0;
    end else if (issue) begin
      if (!kx_last) begin
        kx    <= kx + 8'd1;
        img_q <= img_q + 1'b1;
        wgt_q <= wgt_q + 1'b1;
      end else begin
        kx <= '0;
        if (!ky_last) begin
          ky       <= ky + 8'd1;
          row_base <= row_base + W_STEP;
          img_q    <= row_base + W_STEP;
          wgt_q    <= wgt_q + 1'b1;
        end else begin
          ky <= '0;
          if (!ch_last) begin
            ch       <= ch + 8'd1;
            ch_base  <= ch_base + PLANE_STEP;
            row_base <= ch_base + PLANE_STEP;
            img_q    <= ch_base + PLANE_STEP;
            wgt_q    <= wgt_q + 1'b1;
          end else begin
            ch    <= '0;
            wgt_q <= '0;
            if (!col_last) begin
              ocol     <= ocol + 8'd1;
              win_base <= win_base + 1'b1;
              ch_base  <= win_base + 1'b1;
              row_base <= win_base + 1'b1;
              img_q    <= win_base + 1'b1;
            end else begin
              ocol <= '0;
              if (!row_last) begin
                orow      <= orow + 8'd1;
                line_base <= line_base + W_STEP;
                win_base  <= line_base + W_STEP;
                ch_base   <= line_base + W_STEP;
                row_base  <= line_base + W_STEP;
                img_q     <= line_base + W_STEP;
              end else begin
                orow      <= '0;
                line_base <= '0;
                win_base  <= '0;
                ch_base   <= '0;
                row_base  <= '0;
                img_q     <= '0;
              end
            end
          end
        end
      end
    end
  end

  assign img_addr = img_q;
  assign wgt_addr = wgt_q;

  // tag for the read being issued this cycle; zero when nothing is issued
  tag_t tag_d, tag_q;
  always_comb begin
    tag_d = '0;
    if (issue) begin
      tag_d.first = (kx == 8'd0) && (ky == 8'd0) && (ch == 8'd0);
      tag_d.last  = tap_last;
      tag_d.row   = orow;
      tag_d.col   = ocol;
    end
  end

  // valid pipe matched to the one-cycle memory read latency
  logic [STAGES:1] vld_q;
  wire  [STAGES:0] vld_pipe = {vld_q, issue};

  // delay valid and window tag to line up with returning read data
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      tag_q <= tag_d;
    end
  end

  assign term_valid = vld_pipe[STAGES];
  assign win_first  = tag_q.first;
  assign win_last   = tag_q.last;
  assign out_row    = tag_q.row;
  assign out_col    = tag_q.col;

  logic [NUM_LANES-1:0][BITWIDTH-1:0] wgt_in, lane_data, lane_wgt;
  assign wgt_in = wgt_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    conv1_lane #(.BITWIDTH(BITWIDTH)) u_lane (
      .vld    (term_valid),
      .pix    (img_data),
      .wgt    (wgt_in[i]),
      .data   (lane_data[i]),
      .weight (lane_wgt[i])
    );
  end

  assign data1 = lane_data[0];
  assign data2 = lane_data[1];
  assign data3 = lane_data[2];
  assign data4 = lane_data[3];
  assign data5 = lane_data[4];
  assign data6 = lane_data[5];
  assign weight1 = lane_wgt[0];
  assign weight2 = lane_wgt[1];
  assign weight3 = lane_wgt[2];
  assign weight4 = lane_wgt[3];
  assign weight5 = lane_wgt[4];
  assign weight6 = lane_wgt[5];

endmodule

// File: tb/tb_conv1_stream_feeder.sv
// Directed bench for conv1_stream_feeder: term values on an address-pattern
// memory, window/row boundaries, reset mid-pass, and a full pass on random
// data compared window by window against a software convolution.
module tb_conv1_stream_feeder;
  localparam int NT = 75 * 28 * 28;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, term_valid, win_first, win_last;
  logic [11:0] img_addr;
  logic [6:0]  wgt_addr;
  logic [7:0]  img_data;
  logic [47:0] wgt_data;
  logic [7:0]  out_row, out_col;
  logic [7:0]  data1, data2, data3, data4, data5, data6;
  logic [7:0]  weight1, weight2, weight3, weight4, weight5, weight6;

  conv1_stream_feeder dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_data(img_data), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .term_valid(term_valid), .win_first(win_first), .win_last(win_last),
    .out_row(out_row), .out_col(out_col),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4), .data5(data5), .data6(data6),
    .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .weight4(weight4), .weight5(weight5), .weight6(weight6)
  );

  always #5 clk = ~clk;

  logic [7:0]  img_mem [3072];
  logic [47:0] wgt_mem [75];
  int          golden  [784][6];

  // synchronous read memories, one-cycle latency
  always @(posedge clk) begin
    img_data <= img_mem[img_addr];
    wgt_data <= wgt_mem[wgt_addr];
  end

  wire [5:0][7:0] dv = {data6, data5, data4, data3, data2, data1};
  wire [5:0][7:0] wv = {weight6, weight5, weight4, weight3, weight2, weight1};

  function automatic int prod(input logic [7:0] a, input logic [7:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  // stream monitor: counts, gap detection, per-window dot products
  logic mon_clr = 1'b1;
  int vcnt, nfirst, nlast, gaps, dp_cnt, dp_bad, zero_bad, exp_win;
  logic started, prev_v;
  int acc [6];
  always @(negedge clk) begin : mon
    int nb;
    int a;
    if (mon_clr) begin
      vcnt <= 0; nfirst <= 0; nlast <= 0; gaps <= 0; dp_cnt <= 0; dp_bad <= 0;
      zero_bad <= 0; exp_win <= 0; started <= 1'b0; prev_v <= 1'b0;
    end else begin
      prev_v <= term_valid;
      if (term_valid) begin
        started <= 1'b1;
        vcnt <= vcnt + 1;
        if (started && !prev_v) gaps <= gaps + 1;
        if (win_first) nfirst <= nfirst + 1;
        nb = 0;
        for (int f = 0; f < 6; f++) begin
          a = (win_first ? 0 : acc[f]) + prod(dv[f], wv[f]);
          acc[f] <= a;
          if (win_last && exp_win < 784 && a != golden[exp_win][f]) nb++;
        end
        if (win_last) begin
          nlast <= nlast + 1;
          dp_cnt <= dp_cnt + 1;
          exp_win <= exp_win + 1;
          if (nb != 0 || int'(out_row) * 28 + int'(out_col) != exp_win) dp_bad <= dp_bad + 1;
        end
      end else if ((dv != '0) || (wv != '0) || win_first || win_last) begin
        zero_bad <= zero_bad + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cur = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic goto(input int n);
    while (cur < n) tick();
  endtask

  initial begin
    logic [7:0] wb;
    int s, pa, wa;
    for (int i = 0; i < 3072; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 75; i++) wgt_mem[i] = {6{8'(i)}};
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", term_valid, 0);
    chk("rst_addr", {img_addr, wgt_addr}, 0);
    chk("rst_dw", {data1, weight1, out_row, out_col}, 0);
    reset = 1'b0;
    tick();

    // pass A: address-pattern memory
    cur = 0; start = 1'b1; tick(); start = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_addr", {img_addr, wgt_addr}, 0);
    chk("c1_valid", term_valid, 0);
    goto(2);
    chk("t0_flags", {term_valid, win_first, win_last}, 3'b110);
    chk("t0_dw", {data1, data6, weight1, weight6, out_row, out_col}, 0);
    goto(7);
    chk("t5_data", {data1, data2, data3, data4, data5, data6}, {6{8'd32}});
    chk("t5_wgt", {weight1, weight2, weight3, weight4, weight5, weight6}, {6{8'd5}});
    goto(26);
    chk("t25_addr", {img_addr, wgt_addr}, {12'd1024, 7'd25});
    goto(27);
    chk("t25_data", data1, 8'h00);
    chk("t25_wgt", weight3, 8'd25);
    goto(76);
    chk("t74_flags", {term_valid, win_first, win_last}, 3'b101);
    chk("t74_dw", {data1, weight1}, {8'h84, 8'd74});
    chk("t75_addr", {img_addr, wgt_addr}, {12'd1, 7'd0});
    goto(77);
    chk("t75_tag", {win_first, win_last, out_row, out_col}, {2'b10, 8'd0, 8'd1});
    chk("t75_data", {data1, weight1}, {8'd1, 8'd0});
    chk("t76_addr", {img_addr, wgt_addr}, {12'd2, 7'd1});
    goto(500);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_ctl", {busy, done, term_valid, win_first, win_last}, 0);
    chk("mid_rst_pos", {out_row, out_col, img_addr, wgt_addr}, 0);
    chk("mid_rst_dw", {dv, wv}, 0);
    tick();
    chk("idle_busy", busy, 0);

    // pass B: restart reproduces the first term, then row wrap
    cur = 0; start = 1'b1; tick(); start = 1'b0;
    goto(2);
    chk("b_t0", {term_valid, win_first, win_last, data1, weight1, out_row, out_col},
        {3'b110, 32'd0});
    goto(2027);
    chk("b_w27", {win_first, out_row, out_col}, {1'b1, 8'd0, 8'd27});
    goto(2101);
    chk("wrap_addr", {img_addr, wgt_addr}, {12'd32, 7'd0});
    goto(2102);
    chk("wrap_tag", {win_first, out_row, out_col, data1}, {1'b1, 8'd1, 8'd0, 8'd32});
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // pass C: random data, full frame, stray start mid-pass
    for (int i = 0; i < 3072; i++) img_mem[i] = 8'($urandom);
    for (int i = 0; i < 75; i++) wgt_mem[i] = 48'({$urandom, $urandom});
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        for (int f = 0; f < 6; f++) begin
          s = 0;
          for (int ch = 0; ch < 3; ch++)
            for (int ky = 0; ky < 5; ky++)
              for (int kx = 0; kx < 5; kx++) begin
                pa = ch * 1024 + (r + ky) * 32 + c + kx;
                wa = ch * 25 + ky * 5 + kx;
                wb = wgt_mem[wa][f*8 +: 8];
                s += prod(img_mem[pa], wb);
              end
          golden[r*28 + c][f] = s;
        end
    mon_clr = 1'b0;
    cur = 0; start = 1'b1; tick(); start = 1'b0;
    while (!done && cur < 70000) begin
      if (cur == 1000) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("done_cycle", cur, NT + 2);
    chk("done_busy", busy, 1);
    tick();
    chk("after_done", {busy, done, term_valid}, 0);
    chk("term_count", vcnt, NT);
    chk("gaps", gaps, 0);
    chk("n_first", nfirst, 784);
    chk("n_last", nlast, 784);
    chk("dp_windows", dp_cnt, 784);
    chk("dp_bad", dp_bad, 0);
    chk("idle_zero", zero_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
